// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush/halt sequencer for a 5-stage pipeline without forwarding.
// Optional statistics counters are enabled by defining PIPE_HAZARD_STAT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned DEPTH         = 3,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_r1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_r2_addr,
  input  logic                     id_use_r1,
  input  logic                     id_use_r2,
  input  logic                     id_rw_,
  input  logic [REG_ADDR_BITS-1:0] id_waddr,
  input  logic                     id_halt,
  input  logic                     redirect,
  output logic                     stall,
  output logic                     bubble,
  output logic                     flush,
  output logic                     halt_out,
  output logic [1:0]               state
`ifdef PIPE_HAZARD_STAT_EN
  ,
  output logic [CNT_BITS-1:0]      stall_cnt,
  output logic [CNT_BITS-1:0]      flush_cnt
`endif
);

  localparam int unsigned DC_BITS = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  if (DEPTH < 1 || CNT_BITS < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: DEPTH and CNT_BITS must be at least 1");
  end

  state_t                   cur;
  logic [DEPTH-1:0]         sb_valid;
  logic [REG_ADDR_BITS-1:0] sb_addr [DEPTH];
  logic [DC_BITS-1:0]       drain_cnt;
  logic                     m1, m2, hazard, run, issue;

  // Every in-flight entry counts, including WB: the register file write
  // is not visible to a read in the same cycle.
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sb_valid[i] && sb_addr[i] == id_r1_addr) m1 = 1'b1;
      if (sb_valid[i] && sb_addr[i] == id_r2_addr) m2 = 1'b1;
    end
    if (id_r1_addr == '0) m1 = 1'b0;
    if (id_r2_addr == '0) m2 = 1'b0;
  end

  assign hazard = id_valid & ((id_use_r1 & m1) | (id_use_r2 & m2));
  assign run    = (cur == RUN);
  assign issue  = run & id_valid & ~hazard & ~id_rw_ & ~id_halt & (id_waddr != '0);
  assign stall  = run ? hazard : 1'b1;
  assign bubble = stall;
  assign flush  = redirect & ~hazard & run;
  assign state  = cur;

  always_ff @(posedge clk) begin
    if (rst_) begin
      sb_valid  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) sb_addr[i] <= '0;
      cur       <= RUN;
      drain_cnt <= '0;
      halt_out  <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_addr[i]  <= sb_addr[i-1];
      end
      sb_valid[0] <= issue;
      sb_addr[0]  <= issue ? id_waddr : '0;

      // Counter hits 0 on the same edge that enters HALTED, giving DEPTH+1
      // cycles from halt in ID to halt_out.
      case (cur)
        RUN: begin
          if (id_valid && id_halt && !hazard) begin
            cur       <= DRAIN;
            drain_cnt <= DC_BITS'(DEPTH);
          end
        end
        DRAIN: begin
          if (drain_cnt <= DC_BITS'(1)) begin
            cur       <= HALTED;
            halt_out  <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DC_BITS'(1);
          end
        end
        HALTED:  halt_out <= 1'b1;
        default: cur <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_STAT_EN
  always_ff @(posedge clk) begin
    if (rst_) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (run && stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued per step
// and compared at the following negative clock edge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_r1_addr = '0, id_r2_addr = '0, id_waddr = '0;
  logic       id_use_r1 = 1'b0, id_use_r2 = 1'b0, id_rw_ = 1'b1;
  logic       id_halt = 1'b0, redirect = 1'b0;
  logic       stall, bubble, flush, halt_out;
  logic [1:0] state;
`ifdef PIPE_HAZARD_STAT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int step = 0;
  int exp_scnt = 0;
  int exp_fcnt = 0;

  typedef struct {
    logic       stall;
    logic       flush;
    logic       halt_out;
    logic [1:0] state;
  } exp_t;
  exp_t q[$];

  pipe_hazard_ctrl #(.REG_ADDR_BITS(5), .DEPTH(3), .CNT_BITS(16)) dut (
    .clk(clk), .rst_(rst_), .id_valid(id_valid),
    .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
    .id_rw_(id_rw_), .id_waddr(id_waddr), .id_halt(id_halt),
    .redirect(redirect), .stall(stall), .bubble(bubble), .flush(flush),
    .halt_out(halt_out), .state(state)
`ifdef PIPE_HAZARD_STAT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic rw_n,
                       input logic [4:0] wa, input logic h, input logic rd);
    id_valid = v; id_r1_addr = r1; id_use_r1 = u1; id_r2_addr = r2; id_use_r2 = u2;
    id_rw_ = rw_n; id_waddr = wa; id_halt = h; redirect = rd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
  endtask

  // Queue expectation for the current inputs, check at negedge, advance.
  task automatic cyc(input logic s, input logic f, input logic h, input logic [1:0] st);
    exp_t e, g;
    e.stall = s; e.flush = f; e.halt_out = h; e.state = st;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk("stall", 32'(stall), 32'(g.stall));
    chk("bubble", 32'(bubble), 32'(g.stall));
    chk("flush", 32'(flush), 32'(g.flush));
    chk("halt_out", 32'(halt_out), 32'(g.halt_out));
    chk("state", 32'(state), 32'(g.state));
`ifdef PIPE_HAZARD_STAT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(exp_fcnt));
`endif
    if (g.stall && g.state == 2'd0) exp_scnt++;
    if (g.flush) exp_fcnt++;
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    exp_scnt = 0;
    exp_fcnt = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    idle();
    cyc(0, 0, 0, 2'd0);                                     // reset state

    // Write r5, then read r5: three stalls, issues on the fourth
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd5, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd5, 1, 5'd0, 0, 1, 5'd0, 0, 0);
    repeat (3) cyc(1, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);                                     // r5 not duplicated

    // Write r5, two independent writers of r7, then read r5 via r2
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd5, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd1, 1, 5'd0, 0, 0, 5'd7, 0, 0); cyc(0, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);
    drive(1, 5'd0, 0, 5'd5, 1, 1, 5'd0, 0, 0); cyc(1, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);
    idle(); repeat (3) cyc(0, 0, 0, 2'd0);

    // r0 is never recorded and never hazards
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0); cyc(0, 0, 0, 2'd0);
    // Use bits and id_valid gate the hazard
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd10, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd10, 0, 5'd10, 0, 1, 5'd0, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(0, 5'd10, 1, 5'd10, 1, 1, 5'd0, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd0, 0, 5'd10, 1, 1, 5'd0, 0, 0); cyc(1, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);                                     // WB entry gone

    // Redirect without hazard, then jal (redirect + write r3) and a redirect
    // held back by the r3 hazard
    idle(); cyc(0, 0, 0, 2'd0);
    drive(0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 1); cyc(0, 1, 0, 2'd0);
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd3, 0, 1); cyc(0, 1, 0, 2'd0);
    drive(1, 5'd3, 1, 5'd0, 0, 1, 5'd0, 0, 1);
    repeat (3) cyc(1, 0, 0, 2'd0);
    cyc(0, 1, 0, 2'd0);
    idle(); repeat (3) cyc(0, 0, 0, 2'd0);

    // Reset in the middle of a hazard stall
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd9, 0, 0); cyc(0, 0, 0, 2'd0);
    drive(1, 5'd9, 1, 5'd0, 0, 1, 5'd0, 0, 0); cyc(1, 0, 0, 2'd0);
    do_reset();
    cyc(0, 0, 0, 2'd0);
    idle(); cyc(0, 0, 0, 2'd0);

    // Halt: DRAIN at N+1, HALTED with halt_out at N+4; redirect ignored
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 0); cyc(0, 0, 0, 2'd0);
    idle(); cyc(1, 0, 0, 2'd1);
    drive(0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 1); cyc(1, 0, 0, 2'd1);
    idle(); cyc(1, 0, 0, 2'd1);
    cyc(1, 0, 1, 2'd2);
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 1); cyc(1, 0, 1, 2'd2);
    idle(); cyc(1, 0, 1, 2'd2);

    // Reset releases HALTED
    do_reset();
    cyc(0, 0, 0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Stall/flush/halt sequencer for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding. The block keeps a scoreboard of register writes still in flight between ID and WB. It stalls fetch and decode on read-after-write hazards, injects bubbles into the ID/EX register and flushes the fetched instruction on a taken jump or branch. On halt it drains the pipeline and then asserts a final halt.

Parameters:
REG_ADDR_BITS, 5, register file address width
DEPTH, 3, stages a write stays pending after leaving ID (EX, MEM, WB)
CNT_BITS, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_  input  1  reset; synchronous, active-high
id_valid  input  1  ID stage holds a valid instruction
id_r1_addr  input  REG_ADDR_BITS  source register 1
id_r2_addr  input  REG_ADDR_BITS  source register 2
id_use_r1  input  1  instruction reads r1
id_use_r2  input  1  instruction reads r2
id_rw_  input  1  register write enable, active-low
id_waddr  input  REG_ADDR_BITS  destination register
id_halt  input  1  decoded instruction is halt
redirect  input  1  jump/branch taken, resolved in ID
stall  output  1  hold PC and instruction register
bubble  output  1  load NOP (rw_=1, mem_rw_=1, halt=0) into ID/EX
flush  output  1  invalidate instruction register next cycle
halt_out  output  1  pipeline drained after halt
state  output  2  0=RUN, 1=DRAIN, 2=HALTED

Behaviour:
- Scoreboard: DEPTH entries of {valid, addr}. Entry 0 corresponds to EX and entry DEPTH-1 to WB. The scoreboard shifts on every clock edge.
- Entry 0 loads {1, id_waddr} when issue = id_valid & ~hazard & ~id_rw_ & (id_waddr != 0) in RUN. Otherwise entry 0 loads {0, 0}.
- match(a) = a != 0 and some valid entry has addr == a. All DEPTH entries count, because the WB write is not visible to a same-cycle read.
- hazard = id_valid & ((id_use_r1 & match(id_r1_addr)) | (id_use_r2 & match(id_r2_addr))). This is combinational from registered scoreboard state plus ID inputs.
- RUN: stall = bubble = hazard. A single hazard lasts at most DEPTH cycles.
- flush = redirect & ~hazard & (state == RUN). A redirect during a hazard is ignored; the branch is re-presented once the hazard clears.
- Simultaneous redirect and issue: both occur. The branch's own write (jal) enters the scoreboard.
- RUN -> DRAIN when id_valid & id_halt & ~hazard. The halt instruction itself issues as a non-writing instruction.
- DRAIN: stall = bubble = 1, flush = 0. A drain counter loads DEPTH on entry and decrements each cycle; at 0 the state moves to HALTED.
- HALTED: stall = bubble = 1, halt_out = 1. The block stays in HALTED until reset.
- Total latency from halt in ID to halt_out = DEPTH + 1 cycles.
- Reset (any state, mid-stall included): all scoreboard entries invalid, state = RUN, drain counter = 0, halt_out = 0. stall, bubble and flush are 0 once the ID inputs are idle.
- Register 0 never creates a hazard and is never recorded.

Optional Feature:
Macro PIPE_HAZARD_STAT_EN.
- Defined: adds outputs stall_cnt [CNT_BITS] and flush_cnt [CNT_BITS].
  - stall_cnt increments every cycle that stall = 1 in RUN.
  - flush_cnt increments every cycle that flush = 1.
  - Both saturate at all-ones and clear on reset.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Write r5, then the next cycle read r5 (id_use_r1) -> stall = bubble = 1 for exactly 3 cycles; issues on the 4th; scoreboard holds r5 once.
- Write r5, two independent instructions, then read r5 -> stall for exactly 1 cycle.
- Write r0, then read r0 -> no stall; scoreboard entry 0 stays invalid.
- redirect = 1 with no hazard -> flush = 1 the same cycle; redirect during an r3 hazard -> flush = 0 until the hazard clears, then 1.
- id_halt issued at cycle N -> state = DRAIN at N+1, HALTED with halt_out = 1 at N+4; stall held at 1 from N+1 onward.
- rst_ = 1 during a hazard stall -> next cycle scoreboard empty, stall = 0, state = RUN. With PIPE_HAZARD_STAT_EN, the earlier 3-cycle stall gives stall_cnt = 3 before reset and 0 after.
